// File: rtl/ctrl_pb20000.sv
// ctrl_pb20000 - sequencer for the single-MAC biquad low-pass datapath.
//
// Produces one output sample per start pulse:
//   fk = Uk + a1*fk1 + a2*fk2 ; yk = b0*fk + b1*fk1 + b2*fk2 ; fk2<=fk1, fk1<=fk
//
// Ports
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   start     in   one-cycle request for a new sample (Uk valid)
//   abort     in   synchronous abort back to IDLE, highest priority
//   controlS  out  coefficient select (0 zero, 1 a1, 2 a2, 3 b0, 4 b1, 5 b2)
//   controlC  out  operand select (0 zero, 1 fk1, 2 fk2, 3 fk)
//   controlZ  out  addend select (0 zero, 1 Uk, 2 running sum)
//   acc_en    out  accumulator load strobe
//   fk_en     out  fk register load
//   shift_en  out  delay-line shift
//   busy      out  high outside IDLE
//   done      out  yk final (coincides with the shift)
//   overrun   out  a start request was lost this cycle
//
// Build option
//   PB_PENDING_EN  one-deep pending latch for a start that arrives while busy;
//                  the sequence then chains from SHIFT straight into M1.
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | waiting for start
// M1    | acc = Uk + a1*fk1
// M2    | acc += a2*fk2
// FKLD  | fk <= acc
// M3    | acc = b0*fk
// M4    | acc += b1*fk1
// M5    | acc += b2*fk2
// SHIFT | yk valid, done, fk2<=fk1, fk1<=fk
module ctrl_pb20000 #(
  parameter int MULT_LAT = 0,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  output logic [2:0] controlS,
  output logic [1:0] controlC,
  output logic [1:0] controlZ,
  output logic       acc_en,
  output logic       fk_en,
  output logic       shift_en,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

`ifdef PB_PENDING_EN
  localparam bit PEND_EN = 1'b1;
`else
  localparam bit PEND_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MULT_LAT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_M1    = 3'd1,
    S_M2    = 3'd2,
    S_FKLD  = 3'd3,
    S_M3    = 3'd4,
    S_M4    = 3'd5,
    S_M5    = 3'd6,
    S_SHIFT = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             hold_last;

  assign hold_last = (cnt_q == HOLD_LAST);
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Counter returns to 0 on any transition; it only advances while a MAC
  // step is still waiting for the multiplier pipeline.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    pend_d  = pend_q;
    overrun = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
    end else begin
      if (start && busy) begin
        if (PEND_EN && !pend_q) pend_d = 1'b1;
        else                    overrun = 1'b1;
      end
      case (state_q)
        S_IDLE: if (start) state_d = S_M1;
        S_M1, S_M2, S_M3, S_M4, S_M5: begin
          if (!hold_last) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            case (state_q)
              S_M1:    state_d = S_M2;
              S_M2:    state_d = S_FKLD;
              S_M3:    state_d = S_M4;
              S_M4:    state_d = S_M5;
              default: state_d = S_SHIFT;
            endcase
          end
        end
        S_FKLD: state_d = S_M3;
        S_SHIFT: begin
          // A start seen in this very cycle is consumed directly, as is a
          // request that was parked in the latch earlier.
          if (PEND_EN && (pend_q || start)) begin
            state_d = S_M1;
            pend_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    controlS = 3'd0;
    controlC = 2'd0;
    controlZ = 2'd0;
    acc_en   = 1'b0;
    fk_en    = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_M1: begin
        controlS = 3'd1; controlC = 2'd1; controlZ = 2'd1; acc_en = hold_last;
      end
      S_M2: begin
        controlS = 3'd2; controlC = 2'd2; controlZ = 2'd2; acc_en = hold_last;
      end
      S_FKLD: fk_en = 1'b1;
      S_M3: begin
        controlS = 3'd3; controlC = 2'd3; controlZ = 2'd0; acc_en = hold_last;
      end
      S_M4: begin
        controlS = 3'd4; controlC = 2'd1; controlZ = 2'd2; acc_en = hold_last;
      end
      S_M5: begin
        controlS = 3'd5; controlC = 2'd2; controlZ = 2'd2; acc_en = hold_last;
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
